bin2bcd_seq: RTL

- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") placed directly downstream of the loadable 8-bit counter.
- Takes the counter's `count` value as `bin` and produces packed BCD digits for the seven-segment display driver.
- Iterative, one bit per clock, with a start/busy/done handshake, so the display path carries no wide combinational divider.

---
 rtl/bin2bcd_pkg.sv | 39 +++
 rtl/bin2bcd_seq_seg7_decode.sv | 28 ++
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states
//   SEG_*       : active-low seven-segment patterns, bit order gfedcba
//   min_digits  : smallest digit count able to hold 2^width - 1 in BCD
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned max_val;
    longint unsigned lim;
    int unsigned     d;
    max_val = (64'd1 << width) - 64'd1;
    lim     = 64'd1;
    d       = 0;
    while (lim <= max_val) begin
      lim = lim * 64'd10;
      d   = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder (gfedcba).
//   bcd_i : one BCD digit
//   seg_o : segment pattern; codes 10-15 give a blank display
module seg7_decode
  import bin2bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start_i  : request conversion of bin_i (ignored while busy_o)
//   bin_i    : binary value, sampled on the accepting edge only
//   busy_o   : conversion in progress
//   done_o   : one-cycle pulse, bcd_o valid from this cycle on
//   bcd_o    : packed BCD, units in [3:0], held until the next completion
//   seg_o    : (BIN2BCD_SEG_EN only) registered active-low segments per digit
// Optional feature macro: BIN2BCD_SEG_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef BIN2BCD_SEG_EN
  output logic [7*DIGITS-1:0]   seg_o,
`endif
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small to represent 2^WIDTH-1");
  end

  state_t            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d, sr_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              load_bcd;

  // Add-3 correction on every BCD field before the shift; 4-bit wrap is intended.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[WIDTH+4*i +: 4] >= 4'd5) begin
        sr_adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    load_bcd = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        done_o  = (state_q == StDone);
        state_d = StIdle;
        if (start_i) begin
          sr_d    = {{BcdW{1'b0}}, bin_i};
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        busy_o = 1'b1;
        sr_d   = {sr_adj[SrW-2:0], 1'b0};
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          load_bcd = 1'b1;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    bcd_d = load_bcd ? sr_d[SrW-1 -: BcdW] : bcd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd_o = bcd_q;

`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_d, seg_q;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    seg7_decode u_dec (
      .bcd_i (bcd_d[4*g +: 4]),
      .seg_o (seg_d[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '1;
    end else if (load_bcd) begin
      seg_q <= seg_d;
    end
  end

  assign seg_o = seg_q;
`endif

endmodule
